core_checker: RTL

Stream checker that sits downstream of the core state generator (one instance per TMR replica or on the voted output). It samples the `counter`/`status` pair every valid cycle and locks onto the free-running sequence. Once locked, it flags each sample that breaks the generator's rule `counter(t) = counter(t-1)+1`, `status(t) = counter(t-1)`. This is the observation side of the fault-injection demo: every injected or upset value must be detected, classified, counted and captured.

---
 rtl/core_checker_if.sv | 28 ++
 rtl/core_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/core_checker_if.sv
// Sample/result bundle between a core state generator stream and its checker.
// The master side drives samples and the count clear; the slave (checker) returns results.
interface core_checker_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic [7:0]           counter;
  logic [7:0]           status;
  logic                 clr_count;
  logic                 locked;
  logic                 fault_pulse;
  logic [1:0]           fault_type;
  logic [ERR_CNT_W-1:0] fault_count;
  logic [7:0]           last_bad_counter;
  logic [7:0]           last_bad_status;

  modport master (
    output in_valid, counter, status, clr_count,
    input  locked, fault_pulse, fault_type, fault_count,
           last_bad_counter, last_bad_status
  );

  modport slave (
    input  in_valid, counter, status, clr_count,
    output locked, fault_pulse, fault_type, fault_count,
           last_bad_counter, last_bad_status
  );
endinterface

// File: rtl/core_checker.sv
// Locks onto the counter/status sequence (counter+1, status = previous counter) and
// then detects, classifies, counts and captures every sample that breaks it.
module core_checker #(
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  core_checker_if.slave bus
);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  state_t               state, state_n;
  logic [7:0]           prev_cnt, prev_cnt_n;
  logic                 prev_ok, prev_ok_n;
  logic [3:0]           good_run, good_run_n;
  logic [3:0]           run_inc;
  logic [7:0]           exp_cnt, exp_cnt_n;
  logic                 pair_ok;
  logic                 cnt_bad;
  logic                 st_bad;
  logic                 fault;

  logic                 fault_pulse_q;
  logic [1:0]           fault_type_q;
  logic [ERR_CNT_W-1:0] fault_count_q;
  logic [7:0]           last_bad_counter_q;
  logic [7:0]           last_bad_status_q;

  assign run_inc = good_run + 4'd1;
  assign pair_ok = prev_ok && (bus.counter == 8'(prev_cnt + 8'd1)) && (bus.status == prev_cnt);

  // Faults only exist once locked; in ACQUIRE a bad pair merely restarts the run.
  assign cnt_bad = bus.in_valid && (state == LOCKED) && (bus.counter != exp_cnt);
  assign st_bad  = bus.in_valid && (state == LOCKED) && (bus.status != 8'(exp_cnt - 8'd1));
  assign fault   = cnt_bad || st_bad;

  always_ff @(posedge clk) begin
    if (rst) state <= ACQUIRE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    prev_cnt_n = prev_cnt;
    prev_ok_n  = prev_ok;
    good_run_n = good_run;
    exp_cnt_n  = exp_cnt;
    case (state)
      ACQUIRE: begin
        if (bus.in_valid) begin
          prev_cnt_n = bus.counter;
          prev_ok_n  = 1'b1;
          if (prev_ok) begin
            good_run_n = pair_ok ? run_inc : 4'd0;
            if (pair_ok && (run_inc == 4'(LOCK_CNT))) begin
              state_n   = LOCKED;
              exp_cnt_n = bus.counter + 8'd1;
            end
          end
        end else begin
          good_run_n = 4'd0;
          prev_ok_n  = 1'b0;
        end
      end
      LOCKED: begin
        if (!bus.in_valid) begin
          state_n    = ACQUIRE;
          good_run_n = 4'd0;
          prev_ok_n  = 1'b0;
        end else if (cnt_bad) begin
          // The faulting sample becomes the first acquisition sample.
          state_n    = ACQUIRE;
          good_run_n = 4'd0;
          prev_cnt_n = bus.counter;
          prev_ok_n  = 1'b1;
        end else begin
          exp_cnt_n = exp_cnt + 8'd1;
        end
      end
      default: state_n = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt           <= '0;
      prev_ok            <= 1'b0;
      good_run           <= '0;
      exp_cnt            <= '0;
      fault_pulse_q      <= 1'b0;
      fault_type_q       <= '0;
      fault_count_q      <= '0;
      last_bad_counter_q <= '0;
      last_bad_status_q  <= '0;
    end else begin
      prev_cnt      <= prev_cnt_n;
      prev_ok       <= prev_ok_n;
      good_run      <= good_run_n;
      exp_cnt       <= exp_cnt_n;
      fault_pulse_q <= fault;
      if (fault) begin
        fault_type_q       <= {st_bad, cnt_bad};
        last_bad_counter_q <= bus.counter;
        last_bad_status_q  <= bus.status;
      end
      // A clear coinciding with a fault leaves exactly that one fault counted.
      if (bus.clr_count)
        fault_count_q <= fault ? ERR_CNT_W'(1) : '0;
      else if (fault && !(&fault_count_q))
        fault_count_q <= fault_count_q + ERR_CNT_W'(1);
    end
  end

  assign bus.locked           = (state == LOCKED);
  assign bus.fault_pulse      = fault_pulse_q;
  assign bus.fault_type       = fault_type_q;
  assign bus.fault_count      = fault_count_q;
  assign bus.last_bad_counter = last_bad_counter_q;
  assign bus.last_bad_status  = last_bad_status_q;

endmodule
